// File: rtl/sp_access_ctrl.sv
// Scratchpad access controller: arbitrates the single scratchpad port between the
// systolic-array result write-back and the host bus. Optional macro: SPCTRL_SEC_CHECK_EN.
module sp_access_ctrl #(
    parameter int DW           = 8,
    parameter int BW           = 32,
    parameter int MAX_DIM      = BW / DW,
    parameter int SPN          = 1,
    parameter int ADDR_W       = 4,
    parameter int ELEMENTS_NUM = MAX_DIM * MAX_DIM
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wb_valid_i,
    output logic                       wb_ready_o,
    input  logic [BW*ELEMENTS_NUM-1:0] wb_mat_i,
    input  logic [1:0]                 wb_sec_i,
    output logic                       wb_done_o,
    input  logic                       bus_req_i,
    input  logic                       bus_we_i,
    input  logic [1:0]                 bus_sec_i,
    input  logic [ADDR_W-1:0]          bus_addr_i,
    input  logic [BW-1:0]              bus_wdata_i,
    output logic                       bus_gnt_o,
    output logic                       bus_rvalid_o,
    output logic [BW-1:0]              bus_rdata_o,
`ifdef SPCTRL_SEC_CHECK_EN
    output logic                       bus_err_o,
`endif
    output logic [ADDR_W-1:0]          sp_addr_o,
    output logic [BW-1:0]              sp_data_o,
    output logic                       sp_ena_o,
    output logic [1:0]                 sp_element_w_sel_o,
    output logic [4:0]                 sp_bus_mat_sel_o,
    input  logic [BW-1:0]              sp_row_i,
    output logic                       busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_WB, S_BUS_WR, S_BUS_RD, S_RD_WAIT} state_t;

    state_t              r_state;
    logic                r_tok_bus;
    logic [BW-1:0]       r_elem [ELEMENTS_NUM];
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_sp_addr;
    logic [BW-1:0]       r_sp_data;
    logic                r_sp_ena;
    logic [1:0]          r_sp_wsel;
    logic [4:0]          r_sp_msel;
    logic                r_wb_done;
    logic                r_rvalid;
    logic                r_busy;
    logic                w_wb_ready;
    logic                w_bus_gnt;
    logic                w_wb_bad;
    logic                w_bus_bad;
    logic [ADDR_W-1:0]   w_idx_nxt;

    // Handshakes: a write-back transfers when wb_valid_i && wb_ready_o; a bus access is
    // taken in the cycle bus_gnt_o pulses. Requesters hold their request until then.
    assign w_wb_ready = !reset_i && (r_state == S_IDLE) && wb_valid_i && (!bus_req_i || !r_tok_bus);
    assign w_bus_gnt  = !reset_i && (r_state == S_IDLE) && bus_req_i && (!wb_valid_i || r_tok_bus);
    assign w_idx_nxt  = r_idx + 1'b1;

`ifdef SPCTRL_SEC_CHECK_EN
    logic r_err;
    assign w_wb_bad  = (32'(wb_sec_i) >= 32'(SPN));
    assign w_bus_bad = (32'(bus_sec_i) >= 32'(SPN));
    assign bus_err_o = r_err;
`else
    assign w_wb_bad  = 1'b0;
    assign w_bus_bad = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_tok_bus <= 1'b0;
            r_idx     <= '0;
            r_sp_addr <= '0;
            r_sp_data <= '0;
            r_sp_ena  <= 1'b0;
            r_sp_wsel <= '0;
            r_sp_msel <= '0;
            r_wb_done <= 1'b0;
            r_rvalid  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SPCTRL_SEC_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_wb_done <= 1'b0;
            r_rvalid  <= 1'b0;
`ifdef SPCTRL_SEC_CHECK_EN
            r_err     <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_wb_ready) begin
                        r_tok_bus <= ~r_tok_bus;
                        for (int j = 0; j < ELEMENTS_NUM; j++) begin
                            r_elem[j] <= wb_mat_i[j*BW +: BW];
                        end
                        if (w_wb_bad) begin
                            r_wb_done <= 1'b1;
                        end else begin
                            r_state   <= S_WB;
                            r_busy    <= 1'b1;
                            r_idx     <= '0;
                            r_sp_addr <= '0;
                            r_sp_data <= wb_mat_i[BW-1:0];
                            r_sp_ena  <= 1'b1;
                            r_sp_wsel <= wb_sec_i;
                        end
                    end else if (w_bus_gnt) begin
                        r_tok_bus <= ~r_tok_bus;
                        if (w_bus_bad) begin
                            // Rejected access completes at once; reads still get a zero response.
`ifdef SPCTRL_SEC_CHECK_EN
                            r_err    <= 1'b1;
`endif
                            r_rvalid <= !bus_we_i;
                        end else if (bus_we_i) begin
                            r_state   <= S_BUS_WR;
                            r_busy    <= 1'b1;
                            r_sp_addr <= bus_addr_i;
                            r_sp_data <= bus_wdata_i;
                            r_sp_ena  <= 1'b1;
                            r_sp_wsel <= bus_sec_i;
                        end else begin
                            r_state   <= S_BUS_RD;
                            r_busy    <= 1'b1;
                            r_sp_addr <= bus_addr_i;
                            r_sp_msel <= {1'b1, bus_sec_i, 2'b00};
                        end
                    end
                end
                S_WB: begin
                    if (r_idx == ADDR_W'(ELEMENTS_NUM - 1)) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_sp_ena  <= 1'b0;
                        r_wb_done <= 1'b1;
                    end else begin
                        r_idx     <= w_idx_nxt;
                        r_sp_addr <= w_idx_nxt;
                        r_sp_data <= r_elem[w_idx_nxt];
                    end
                end
                S_BUS_WR: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_sp_ena <= 1'b0;
                end
                S_BUS_RD: begin
                    r_state   <= S_RD_WAIT;
                    r_sp_msel <= '0;
                    r_rvalid  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The scratchpad presents the selected row during RD_WAIT; forward it in that cycle.
    assign bus_rdata_o        = (r_state == S_RD_WAIT) ? sp_row_i : '0;
    assign wb_ready_o         = w_wb_ready;
    assign bus_gnt_o          = w_bus_gnt;
    assign wb_done_o          = r_wb_done;
    assign bus_rvalid_o       = r_rvalid;
    assign sp_addr_o          = r_sp_addr;
    assign sp_data_o          = r_sp_data;
    assign sp_ena_o           = r_sp_ena;
    assign sp_element_w_sel_o = r_sp_wsel;
    assign sp_bus_mat_sel_o   = r_sp_msel;
    assign busy_o             = r_busy;
endmodule

// File: tb/tb_sp_access_ctrl.sv
// Directed bench for sp_access_ctrl with a small registered scratchpad model.
module tb_sp_access_ctrl;
    localparam int BW = 32;
    localparam int AW = 4;
    localparam int EN = 16;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            wb_valid_i;
    logic            wb_ready_o;
    logic [BW*EN-1:0] wb_mat_i;
    logic [1:0]      wb_sec_i;
    logic            wb_done_o;
    logic            bus_req_i;
    logic            bus_we_i;
    logic [1:0]      bus_sec_i;
    logic [AW-1:0]   bus_addr_i;
    logic [BW-1:0]   bus_wdata_i;
    logic            bus_gnt_o;
    logic            bus_rvalid_o;
    logic [BW-1:0]   bus_rdata_o;
`ifdef SPCTRL_SEC_CHECK_EN
    logic            bus_err_o;
`endif
    logic [AW-1:0]   sp_addr_o;
    logic [BW-1:0]   sp_data_o;
    logic            sp_ena_o;
    logic [1:0]      sp_element_w_sel_o;
    logic [4:0]      sp_bus_mat_sel_o;
    logic [BW-1:0]   sp_row_i;
    logic            busy_o;

    int n_total = 0;
    int n_bad   = 0;

    logic [BW-1:0] mem [EN];

    sp_access_ctrl dut (
        .clk_i(clk), .reset_i(reset_i),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_mat_i(wb_mat_i),
        .wb_sec_i(wb_sec_i), .wb_done_o(wb_done_o),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_sec_i(bus_sec_i),
        .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_gnt_o(bus_gnt_o),
        .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
`ifdef SPCTRL_SEC_CHECK_EN
        .bus_err_o(bus_err_o),
`endif
        .sp_addr_o(sp_addr_o), .sp_data_o(sp_data_o), .sp_ena_o(sp_ena_o),
        .sp_element_w_sel_o(sp_element_w_sel_o), .sp_bus_mat_sel_o(sp_bus_mat_sel_o),
        .sp_row_i(sp_row_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Scratchpad model: synchronous write, registered row output.
    initial begin
        for (int i = 0; i < EN; i++) mem[i] = '0;
        sp_row_i = '0;
    end
    always @(posedge clk) begin
        if (sp_ena_o) mem[sp_addr_o] <= sp_data_o;
        sp_row_i <= mem[sp_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb_valid_i  = 1'b0;
        wb_sec_i    = '0;
        bus_req_i   = 1'b0;
        bus_we_i    = 1'b0;
        bus_sec_i   = '0;
        bus_addr_i  = '0;
        bus_wdata_i = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic set_mat(input logic [31:0] base);
        for (int j = 0; j < EN; j++) wb_mat_i[j*BW +: BW] = base + 32'(j);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(wb_ready_o), 0);
        chk({tag, "_gnt"}, 32'(bus_gnt_o), 0);
        chk({tag, "_done"}, 32'(wb_done_o), 0);
        chk({tag, "_rvalid"}, 32'(bus_rvalid_o), 0);
        chk({tag, "_rdata"}, bus_rdata_o, 0);
        chk({tag, "_addr"}, 32'(sp_addr_o), 0);
        chk({tag, "_data"}, sp_data_o, 0);
        chk({tag, "_ena"}, 32'(sp_ena_o), 0);
        chk({tag, "_wsel"}, 32'(sp_element_w_sel_o), 0);
        chk({tag, "_msel"}, 32'(sp_bus_mat_sel_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
`ifdef SPCTRL_SEC_CHECK_EN
        chk({tag, "_err"}, 32'(bus_err_o), 0);
`endif
    endtask

    initial begin
        int n;
        reset_i  = 1'b1;
        wb_mat_i = '0;
        clear_inputs();

        // Reset state, with a write-back request present during reset
        wb_valid_i = 1'b1;
        tick();
        tick();
        #1;
        chk_all_zero("rst");
        wb_valid_i = 1'b0;
        reset_i    = 1'b0;

        // Write-back burst, element j = j+1, section 0
        set_mat(32'd1);
        wb_sec_i   = 2'd0;
        wb_valid_i = 1'b1;
        #1;
        chk("wb1_ready", 32'(wb_ready_o), 1);
        chk("wb1_gnt", 32'(bus_gnt_o), 0);
        tick();
        wb_valid_i = 1'b0;
        for (int j = 0; j < EN; j++) begin
            chk("wb1_ena", 32'(sp_ena_o), 1);
            chk("wb1_addr", 32'(sp_addr_o), 32'(j));
            chk("wb1_data", sp_data_o, 32'(j + 1));
            chk("wb1_done_early", 32'(wb_done_o), 0);
            chk("wb1_busy", 32'(busy_o), 1);
            tick();
        end
        chk("wb1_end_ena", 32'(sp_ena_o), 0);
        chk("wb1_done", 32'(wb_done_o), 1);
        chk("wb1_end_busy", 32'(busy_o), 0);
        tick();
        chk("wb1_done_pulse", 32'(wb_done_o), 0);
        chk("wb1_no_second", 32'(sp_ena_o), 0);
        chk("wb1_idle_busy", 32'(busy_o), 0);

        // Bus write addr 5, then read it back
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_sec_i = 2'd0;
        bus_addr_i = 4'd5; bus_wdata_i = 32'hA5A5_A5A5;
        #1;
        chk("bw_gnt", 32'(bus_gnt_o), 1);
        chk("bw_ready", 32'(wb_ready_o), 0);
        tick();
        bus_req_i = 1'b0;
        chk("bw_ena", 32'(sp_ena_o), 1);
        chk("bw_addr", 32'(sp_addr_o), 5);
        chk("bw_data", sp_data_o, 32'hA5A5_A5A5);
        chk("bw_wsel", 32'(sp_element_w_sel_o), 0);
        chk("bw_busy", 32'(busy_o), 1);
        tick();
        chk("bw_end_ena", 32'(sp_ena_o), 0);
        chk("bw_end_busy", 32'(busy_o), 0);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 4'd5;
        #1;
        chk("br_gnt", 32'(bus_gnt_o), 1);
        tick();
        bus_req_i = 1'b0;
        chk("br_msel", 32'(sp_bus_mat_sel_o), 16);
        chk("br_addr", 32'(sp_addr_o), 5);
        chk("br_ena", 32'(sp_ena_o), 0);
        chk("br_rvalid_early", 32'(bus_rvalid_o), 0);
        tick();
        chk("br_rvalid", 32'(bus_rvalid_o), 1);
        chk("br_rdata", bus_rdata_o, 32'hA5A5_A5A5);
        chk("br_msel_clr", 32'(sp_bus_mat_sel_o), 0);
        tick();
        chk("br_rvalid_pulse", 32'(bus_rvalid_o), 0);
        chk("br_busy", 32'(busy_o), 0);

`ifdef SPCTRL_SEC_CHECK_EN
        // Out-of-range section: read rejected at once, write-back dropped
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_sec_i = 2'd2; bus_addr_i = 4'd5;
        #1;
        chk("se_gnt", 32'(bus_gnt_o), 1);
        tick();
        bus_req_i = 1'b0;
        chk("se_err", 32'(bus_err_o), 1);
        chk("se_rvalid", 32'(bus_rvalid_o), 1);
        chk("se_rdata", bus_rdata_o, 0);
        chk("se_msel", 32'(sp_bus_mat_sel_o), 0);
        chk("se_busy", 32'(busy_o), 0);
        tick();
        chk("se_err_pulse", 32'(bus_err_o), 0);
        wb_valid_i = 1'b1; wb_sec_i = 2'd3;
        #1;
        chk("sew_ready", 32'(wb_ready_o), 1);
        tick();
        wb_valid_i = 1'b0;
        chk("sew_done", 32'(wb_done_o), 1);
        chk("sew_ena", 32'(sp_ena_o), 0);
        tick();
        chk("sew_done_pulse", 32'(wb_done_o), 0);
`else
        // Section beyond SPN passes through unchecked: select = 16 + 4*1
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_sec_i = 2'd1; bus_addr_i = 4'd5;
        #1;
        chk("bs1_gnt", 32'(bus_gnt_o), 1);
        tick();
        bus_req_i = 1'b0;
        chk("bs1_msel", 32'(sp_bus_mat_sel_o), 20);
        tick();
        chk("bs1_rvalid", 32'(bus_rvalid_o), 1);
        tick();
`endif

        // Simultaneous requests from reset: WB first, bus next, then WB again
        do_reset();
        set_mat(32'd1);
        wb_valid_i = 1'b1; wb_sec_i = 2'd0;
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_sec_i = 2'd0;
        bus_addr_i = 4'd3; bus_wdata_i = 32'h33;
        #1;
        chk("arb_ready", 32'(wb_ready_o), 1);
        chk("arb_gnt", 32'(bus_gnt_o), 0);
        tick();
        for (int k = 0; k < EN; k++) begin
            chk("arb_gnt_wait", 32'(bus_gnt_o), 0);
            chk("arb_ready_wait", 32'(wb_ready_o), 0);
            tick();
        end
        chk("arb_done", 32'(wb_done_o), 1);
        chk("arb_gnt2", 32'(bus_gnt_o), 1);
        chk("arb_ready2", 32'(wb_ready_o), 0);
        tick();
        bus_req_i = 1'b0;
        chk("arb_bw_ena", 32'(sp_ena_o), 1);
        chk("arb_bw_addr", 32'(sp_addr_o), 3);
        chk("arb_bw_data", sp_data_o, 32'h33);
        tick();
        bus_req_i = 1'b1;
        #1;
        chk("arb_ready3", 32'(wb_ready_o), 1);
        chk("arb_gnt3", 32'(bus_gnt_o), 0);

        // Bus read raised mid-burst waits for the burst to end
        do_reset();
        set_mat(32'h100);
        wb_valid_i = 1'b1;
        tick();
        wb_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("mid_idx", 32'(sp_addr_o), 3);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_sec_i = 2'd0; bus_addr_i = 4'd5;
        #1;
        chk("mid_gnt_blocked", 32'(bus_gnt_o), 0);
        n = 0;
        while (!bus_gnt_o && n < 30) begin
            tick();
            n++;
        end
        chk("mid_gnt_delay", 32'(n), 13);
        chk("mid_done", 32'(wb_done_o), 1);
        tick();
        bus_req_i = 1'b0;
        chk("mid_msel", 32'(sp_bus_mat_sel_o), 16);
        tick();
        chk("mid_rvalid", 32'(bus_rvalid_o), 1);
        chk("mid_rdata", bus_rdata_o, 32'h105);
        tick();
        chk("mid_rvalid_pulse", 32'(bus_rvalid_o), 0);

        // Reset in the middle of a burst
        set_mat(32'd1);
        wb_valid_i = 1'b1;
        tick();
        wb_valid_i = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("abort_idx", 32'(sp_addr_o), 7);
        reset_i = 1'b1;
        tick();
        chk_all_zero("abort");
        reset_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("abort_no_ena", 32'(sp_ena_o), 0);
            chk("abort_no_done", 32'(wb_done_o), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
